// File: rtl/doodler_motion.sv
// Per-frame motion controller for the doodler sprite: jump/gravity physics,
// horizontal steering with screen wrap, world-scroll requests and game-over freeze.
module doodler_motion #(
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 400,
  parameter int SIZE        = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 10,
  parameter int X_STEP      = 2,
  parameter int SCROLL_LINE = 160
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       plat_hit,
  output logic [9:0] DoodleX,
  output logic [9:0] DoodleY,
  output logic [9:0] Doodle_size,
  output logic       scroll_valid,
  output logic [9:0] scroll_amt,
  output logic       dead,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] FALL = 2'd2;
  localparam logic [1:0] DEAD = 2'd3;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_START = 8'h2C;

  localparam logic signed [9:0]  VEL_JUMP = 10'(-JUMP_V);
  localparam logic signed [10:0] GRAV     = 11'(GRAVITY);
  localparam logic signed [10:0] FALL_MAX = 11'(MAX_FALL);
  localparam logic signed [10:0] SLINE    = 11'(SCROLL_LINE);
  localparam logic signed [10:0] Y_DEATH  = 11'(Y_MAX + SIZE);
  localparam logic signed [10:0] XSTEP    = 11'(X_STEP);
  localparam logic signed [10:0] XMAX     = 11'(X_MAX);
  localparam logic signed [10:0] XMOD     = 11'(X_MAX + 1);

  logic              frame_clk_d;
  logic              tick;
  logic signed [9:0] vel;
  logic signed [10:0] y_next, vel_inc, x_left, x_right;
  logic [9:0]        x_steer;
  logic              start_key;

  assign tick        = frame_clk & ~frame_clk_d;
  assign start_key   = (keycode == KEY_START);
  assign dead        = (state == DEAD);
  assign Doodle_size = 10'(SIZE);

  // All arithmetic is 11-bit signed so negative intermediates wrap/clamp correctly.
  always_comb begin
    y_next  = $signed({1'b0, DoodleY}) + $signed({vel[9], vel});
    vel_inc = $signed({vel[9], vel}) + GRAV;
    x_left  = $signed({1'b0, DoodleX}) - XSTEP;
    if (x_left < 11'sd0) x_left = x_left + XMOD;
    x_right = $signed({1'b0, DoodleX}) + XSTEP;
    if (x_right > XMAX) x_right = x_right - XMOD;
    case (keycode)
      KEY_LEFT:  x_steer = x_left[9:0];
      KEY_RIGHT: x_steer = x_right[9:0];
      default:   x_steer = DoodleX;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      DoodleX      <= 10'(X_INIT);
      DoodleY      <= 10'(Y_INIT);
      vel          <= '0;
      scroll_valid <= 1'b0;
      scroll_amt   <= '0;
      frame_clk_d  <= 1'b0;
    end else begin
      frame_clk_d  <= frame_clk;
      scroll_valid <= 1'b0;
      scroll_amt   <= '0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (start_key) begin
              state <= RISE;
              vel   <= VEL_JUMP;
            end
          end
          RISE: begin
            DoodleX <= x_steer;
            // Sprite is pinned at the scroll line; the overshoot moves the world instead.
            if (y_next < SLINE) begin
              DoodleY      <= 10'(SCROLL_LINE);
              scroll_valid <= 1'b1;
              scroll_amt   <= 10'(SLINE - y_next);
            end else begin
              DoodleY <= y_next[9:0];
            end
            vel <= vel_inc[9:0];
            if (vel_inc >= 11'sd0) state <= FALL;
          end
          FALL: begin
            DoodleX <= x_steer;
            if (plat_hit) begin
              vel   <= VEL_JUMP;
              state <= RISE;
            end else begin
              DoodleY <= y_next[9:0];
              vel     <= (vel_inc > FALL_MAX) ? FALL_MAX[9:0] : vel_inc[9:0];
              if (y_next > Y_DEATH) state <= DEAD;
            end
          end
          default: begin
            if (start_key) begin
              state   <= IDLE;
              DoodleX <= 10'(X_INIT);
              DoodleY <= 10'(Y_INIT);
              vel     <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_doodler_motion.sv
// Scoreboard bench for doodler_motion: three instances (X_INIT 320/0/1) share stimulus
// so wrap-around at both screen edges is exercised alongside the main physics sequence.
module tb_doodler_motion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       plat_hit;

  logic [9:0] x0, y0, sz0, sa0, xa, ya, sza, saa, xb, yb, szb, sab;
  logic       sv0, dd0, sva, dda, svb, ddb;
  logic [1:0] st0, sta, stb;

  always #5 clk = ~clk;

  doodler_motion u_dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .keycode(keycode), .plat_hit(plat_hit),
    .DoodleX(x0), .DoodleY(y0), .Doodle_size(sz0), .scroll_valid(sv0), .scroll_amt(sa0),
    .dead(dd0), .state(st0));

  doodler_motion #(.X_INIT(0)) u_wa (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .keycode(keycode), .plat_hit(plat_hit),
    .DoodleX(xa), .DoodleY(ya), .Doodle_size(sza), .scroll_valid(sva), .scroll_amt(saa),
    .dead(dda), .state(sta));

  doodler_motion #(.X_INIT(1)) u_wb (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .keycode(keycode), .plat_hit(plat_hit),
    .DoodleX(xb), .DoodleY(yb), .Doodle_size(szb), .scroll_valid(svb), .scroll_amt(sab),
    .dead(ddb), .state(stb));

  typedef struct {
    logic [1:0] st;
    logic [9:0] x0, xa, xb, y;
    logic       sv;
    logic [9:0] sa;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   have_last = 1'b0;
  bit   ev = 1'b0;
  logic fprev = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(input int st, input int ex0, input int exa, input int exb,
                              input int ey, input int esv = 0, input int esa = 0);
    exp_t r;
    r.st = 2'(st); r.x0 = 10'(ex0); r.xa = 10'(exa); r.xb = 10'(exb);
    r.y = 10'(ey); r.sv = 1'(esv); r.sa = 10'(esa);
    return r;
  endfunction

  task automatic check(input string name, input exp_t e);
    logic ok;
    logic ed;
    ed = (e.st == 2'd3);
    ok = (st0 == e.st) && (sta == e.st) && (stb == e.st) &&
         (x0 == e.x0) && (xa == e.xa) && (xb == e.xb) &&
         (y0 == e.y) && (ya == e.y) && (yb == e.y) &&
         (sv0 == e.sv) && (sva == e.sv) && (svb == e.sv) &&
         (sa0 == e.sa) && (saa == e.sa) && (sab == e.sa) &&
         (dd0 == ed) && (dda == ed) && (ddb == ed) &&
         (sz0 == 10'd4) && (sza == 10'd4) && (szb == 10'd4);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @%0t: got st=%0d/%0d/%0d x=%0d/%0d/%0d y=%0d/%0d/%0d sv=%0d amt=%0d dead=%0d size=%0d, want st=%0d x=%0d/%0d/%0d y=%0d sv=%0d amt=%0d dead=%0d size=4",
               name, $time, st0, sta, stb, x0, xa, xb, y0, ya, yb, sv0, sa0, dd0, sz0,
               e.st, e.x0, e.xa, e.xb, e.y, e.sv, e.sa, ed);
    end
  endtask

  // An update is due on any reset edge or on the first edge frame_clk is seen high.
  always @(posedge clk) begin
    ev    = !rst_n || (frame_clk && !fprev);
    fprev = rst_n ? frame_clk : 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ev) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL no_expect @%0t: got update with empty scoreboard, want none", $time);
      end else begin
        e = q.pop_front();
        check("update", e);
        last = e;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      e = last; e.sv = 1'b0; e.sa = '0;
      check("hold", e);
    end
  end

  task automatic tick(input logic [7:0] k, input logic hit, input int hold, input exp_t e);
    keycode   = k;
    plat_hit  = hit;
    frame_clk = 1'b1;
    q.push_back(e);
    repeat (hold) @(negedge clk);
    frame_clk = 1'b0;
    @(negedge clk);
  endtask

  int off [12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
  logic [7:0] rkey [12] = '{8'h04, 8'h07, 8'h07, 8'h04, 8'h04, 8'h2C, 8'h05,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  int rx0 [12] = '{318, 320, 322, 320, 318, 318, 318, 318, 318, 318, 318, 318};
  int rxa [12] = '{638, 0, 2, 0, 638, 638, 638, 638, 638, 638, 638, 638};
  int rxb [12] = '{639, 1, 3, 1, 639, 639, 639, 639, 639, 639, 639, 639};
  int fy1 [5]  = '{322, 323, 325, 328, 332};
  int fy2 [10] = '{160, 161, 163, 166, 170, 175, 181, 188, 196, 205};

  initial begin
    rst_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; plat_hit = 1'b0;
    q.push_back(mk(0, 320, 0, 1, 400));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start, frame strobe held for 5 cycles: one update only
    tick(8'h2C, 1'b0, 5, mk(1, 320, 0, 1, 400));

    // first jump with steering across both screen edges
    for (int i = 0; i < 12; i++)
      tick(rkey[i], 1'b0, 1, mk(i == 11 ? 2 : 1, rx0[i], rxa[i], rxb[i], 400 - off[i]));

    for (int i = 0; i < 5; i++)
      tick(8'h00, 1'b0, 1, mk(2, 318, 638, 639, fy1[i]));

    // landing: Y unchanged, back to RISE; plat_hit ignored while rising
    tick(8'h00, 1'b1, 1, mk(1, 318, 638, 639, 332));
    for (int i = 0; i < 12; i++)
      tick(8'h00, 1'b1, 1, mk(i == 11 ? 2 : 1, 318, 638, 639, 332 - off[i]));
    tick(8'h00, 1'b1, 1, mk(1, 318, 638, 639, 254));
    for (int i = 0; i < 12; i++)
      tick(8'h00, 1'b0, 1, mk(i == 11 ? 2 : 1, 318, 638, 639, 254 - off[i]));
    tick(8'h00, 1'b1, 1, mk(1, 318, 638, 639, 176));

    // scroll line: 164 stays, then pinned at 160 with overshoot as scroll_amt
    tick(8'h00, 1'b0, 1, mk(1, 318, 638, 639, 164));
    tick(8'h00, 1'b0, 1, mk(1, 318, 638, 639, 160, 1, 7));
    for (int a = 10; a >= 1; a--)
      tick(8'h00, 1'b0, 1, mk(a == 1 ? 2 : 1, 318, 638, 639, 160, 1, a));

    // fall with terminal velocity to death at 485
    tick(8'h04, 1'b0, 1, mk(2, 316, 636, 637, fy2[0]));
    for (int i = 1; i < 10; i++)
      tick(8'h00, 1'b0, 1, mk(2, 316, 636, 637, fy2[i]));
    for (int n = 1; n <= 28; n++)
      tick(8'h00, 1'b0, 1, mk(n == 28 ? 3 : 2, 316, 636, 637, 205 + 10 * n));

    // dead is frozen; restart returns to init; IDLE ignores steering
    tick(8'h04, 1'b1, 1, mk(3, 316, 636, 637, 485));
    tick(8'h2C, 1'b0, 1, mk(0, 320, 0, 1, 400));
    tick(8'h04, 1'b0, 1, mk(0, 320, 0, 1, 400));

    // reset mid-rise, coincident with a frame strobe
    tick(8'h2C, 1'b0, 1, mk(1, 320, 0, 1, 400));
    for (int i = 0; i < 3; i++)
      tick(8'h00, 1'b0, 1, mk(1, 320, 0, 1, 400 - off[i]));
    rst_n = 1'b0; frame_clk = 1'b1;
    q.push_back(mk(0, 320, 0, 1, 400));
    @(negedge clk);
    rst_n = 1'b1; frame_clk = 1'b0;
    @(negedge clk);
    tick(8'h2C, 1'b0, 1, mk(1, 320, 0, 1, 400));
    tick(8'h00, 1'b0, 1, mk(1, 320, 0, 1, 388));

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/doodler_motion.md
# doodler_motion

Per-frame motion controller for the player sprite (the doodler). It supplies the position and size that the colour mapper uses to draw the sprite, running vertical jump/gravity physics and horizontal keyboard steering with screen wrap-around. It also requests world scroll when the doodler rises above the scroll line. The game-over state freezes the sprite until restart.

## Interface
Parameters:
- X_INIT, 320, reset/restart X centre (pixels)
- Y_INIT, 400, reset/restart Y centre (pixels)
- SIZE, 4, sprite half-width, driven on Doodle_size
- X_MAX, 639, rightmost column; X wraps modulo X_MAX+1
- Y_MAX, 479, bottom row
- JUMP_V, 12, launch speed (pixels/frame, upward)
- GRAVITY, 1, velocity increment per frame
- MAX_FALL, 10, terminal downward velocity
- X_STEP, 2, horizontal pixels per frame
- SCROLL_LINE, 160, minimum Y while rising

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- frame_clk  in  1  VGA vsync-rate frame strobe, synchronous to Clk
- keycode  in  8  current key: 0x04 left, 0x07 right, 0x2C start; other codes mean no key
- plat_hit  in  1  platform contact at the current DoodleX/DoodleY, combinational from platform logic
- DoodleX  out  10  sprite centre X
- DoodleY  out  10  sprite centre Y
- Doodle_size  out  10  constant SIZE
- scroll_valid  out  1  one-cycle scroll request
- scroll_amt  out  10  pixels to scroll world down; valid with scroll_valid, otherwise 0
- dead  out  1  high in DEAD
- state  out  2  IDLE=0, RISE=1, FALL=2, DEAD=3

## Operation
- frame_clk is registered into frame_clk_d. tick = frame_clk & ~frame_clk_d.
- All state, position and velocity updates occur only on Clk edges where tick=1. scroll_valid is the only exception: it is cleared on the following edge.
- Velocity vel is a signed 10-bit value; negative means upward. Sums are formed at 11 bits signed: Ynext = Y + vel.
- Horizontal (RISE and FALL only, at tick):
  - 0x04: X = (X - X_STEP) mod (X_MAX+1).
  - 0x07: X = (X + X_STEP) mod (X_MAX+1).
  - Any other keycode: X held.
- IDLE: position holds at the init values.
  - At a tick with keycode 0x2C: go to RISE, vel = -JUMP_V. Y is not moved on this tick.
- RISE: at tick, compute Ynext.
  - If Ynext < SCROLL_LINE: Y = SCROLL_LINE, scroll_amt = SCROLL_LINE - Ynext, scroll_valid = 1.
  - Otherwise: Y = Ynext.
  - Then vel = vel + GRAVITY. If the new vel >= 0, go to FALL.
- FALL: at tick, plat_hit is sampled first.
  - If plat_hit=1: vel = -JUMP_V, go to RISE, Y unchanged.
  - Else: Y = Ynext and vel = min(vel + GRAVITY, MAX_FALL).
  - If Ynext > Y_MAX + SIZE: go to DEAD with Y = Ynext.
- plat_hit is ignored in IDLE, RISE and DEAD.
- DEAD: X, Y and vel are frozen and dead = 1.
  - At a tick with keycode 0x2C: go to IDLE, X = X_INIT, Y = Y_INIT, vel = 0.
- Reset (Reset_n=0 at a Clk edge, in any state, including mid-jump):
  - state = IDLE, DoodleX = X_INIT, DoodleY = Y_INIT, vel = 0.
  - scroll_valid = 0, scroll_amt = 0, dead = 0, frame_clk_d = 0.
- Doodle_size is always SIZE.

## Timing
- Latency: outputs update on the Clk edge where frame_clk is first seen high. They are visible one cycle after frame_clk rises, then held constant for the rest of the frame.
- frame_clk held high does not produce further ticks. A new tick requires frame_clk to return low.
- scroll_valid is high for exactly one Clk cycle per scroll event, coincident with the new DoodleY. scroll_amt returns to 0 on the next cycle.
- Simultaneous events on one tick:
  - plat_hit in FALL takes precedence over the death check.
  - Horizontal motion is applied in the same tick as any vertical update or state change, but not on the IDLE to RISE or DEAD to IDLE ticks.
- Reset takes precedence over tick.

## Test plan
- Reset, then release: DoodleX=320, DoodleY=400, state=0, dead=0, scroll_valid=0. Hold frame_clk high for 5 cycles: exactly one update.
- Start with 0x2C at tick: state=1. The next 12 ticks give Y=388, 377, …, 322. After tick 12, state=2 and vel=0.
- Wrap: in RISE with X=0, keycode 0x04 at tick gives X=638. With X=639, keycode 0x07 gives X=1.
- Scroll: in RISE with Y=170 and vel=-12, tick gives Y=160, scroll_amt=2, scroll_valid high for 1 cycle then 0.
- Landing and death:
  - In FALL with Y=300, vel=5 and plat_hit=1 at tick: state=1, vel=-12, Y=300.
  - In FALL with Y=478, vel=10 and plat_hit=0: Y=488, state=3, dead=1. A following tick with 0x2C gives state=0, X=320, Y=400.
- Reset_n low mid-RISE at Y=350: the next edge gives state=0, Y=400, vel=0, scroll_valid=0.
